// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single write port of the 32x32 register file between two
//   writeback requesters (A = ALU, B = load). Each requester has its own
//   DEPTH-entry FIFO. One head is drained per cycle, round-robin when both
//   FIFOs hold entries. It also flags read-after-write hazards for the two
//   issue-stage read addresses.
//
// Ports
//   Clk, ResetN                      clock, synchronous active-low reset
//   ValidA/ReadyA/AddrA/DataA        requester A push handshake
//   ValidB/ReadyB/AddrB/DataB        requester B push handshake
//   RegWrite/WriteRegister/WriteData registered register-file write port
//   ReadRegister1/2                  read addresses checked for hazards
//   Hazard1/2                        read address has an uncommitted write
module regfile_write_arbiter #(
   parameter int DEPTH = 2,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          Clk,
   input  logic          ResetN,
   input  logic          ValidA,
   output logic          ReadyA,
   input  logic [AW-1:0] AddrA,
   input  logic [DW-1:0] DataA,
   input  logic          ValidB,
   output logic          ReadyB,
   input  logic [AW-1:0] AddrB,
   input  logic [DW-1:0] DataB,
   output logic          RegWrite,
   output logic [AW-1:0] WriteRegister,
   output logic [DW-1:0] WriteData,
   input  logic [AW-1:0] ReadRegister1,
   input  logic [AW-1:0] ReadRegister2,
   output logic          Hazard1,
   output logic          Hazard2
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0] addrMemA [DEPTH];
   logic [DW-1:0] dataMemA [DEPTH];
   logic [AW-1:0] addrMemB [DEPTH];
   logic [DW-1:0] dataMemB [DEPTH];

   logic [PW-1:0] rdPtrA, wrPtrA, rdPtrB, wrPtrB;
   logic [CW-1:0] cntA, cntB;
   logic          prioB;   // 0: A wins the next tie, 1: B wins

   logic pushA, pushB, popA, popB, notEmptyA, notEmptyB;
   logic [DEPTH-1:0] entValidA, entValidB;

   // Ready depends on the registered count only; a full FIFO never
   // accepts, even while it is being popped.
   assign ReadyA = ResetN && (cntA != FULL);
   assign ReadyB = ResetN && (cntB != FULL);
   assign pushA  = ValidA && ReadyA;
   assign pushB  = ValidB && ReadyB;

   assign notEmptyA = (cntA != '0);
   assign notEmptyB = (cntB != '0);
   assign popA      = notEmptyA && (!notEmptyB || !prioB);
   assign popB      = notEmptyB && (!notEmptyA ||  prioB);

   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         rdPtrA        <= '0;
         wrPtrA        <= '0;
         cntA          <= '0;
         rdPtrB        <= '0;
         wrPtrB        <= '0;
         cntB          <= '0;
         prioB         <= 1'b0;
         RegWrite      <= 1'b0;
         WriteRegister <= '0;
         WriteData     <= '0;
      end else begin
         if (pushA) begin
            addrMemA[wrPtrA] <= AddrA;
            dataMemA[wrPtrA] <= DataA;
            wrPtrA           <= wrPtrA + PW'(1);
         end
         if (pushB) begin
            addrMemB[wrPtrB] <= AddrB;
            dataMemB[wrPtrB] <= DataB;
            wrPtrB           <= wrPtrB + PW'(1);
         end
         if (popA) rdPtrA <= rdPtrA + PW'(1);
         if (popB) rdPtrB <= rdPtrB + PW'(1);

         case ({pushA, popA})
            2'b10:   cntA <= cntA + CW'(1);
            2'b01:   cntA <= cntA - CW'(1);
            default: cntA <= cntA;
         endcase
         case ({pushB, popB})
            2'b10:   cntB <= cntB + CW'(1);
            2'b01:   cntB <= cntB - CW'(1);
            default: cntB <= cntB;
         endcase

         // Whoever is served hands the next tie to the other requester.
         if (popA) begin
            prioB         <= 1'b1;
            RegWrite      <= (addrMemA[rdPtrA] != '0);
            WriteRegister <= addrMemA[rdPtrA];
            WriteData     <= dataMemA[rdPtrA];
         end else if (popB) begin
            prioB         <= 1'b0;
            RegWrite      <= (addrMemB[rdPtrB] != '0);
            WriteRegister <= addrMemB[rdPtrB];
            WriteData     <= dataMemB[rdPtrB];
         end else begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
         end
      end
   end

   // Slot g holds a live entry when its distance from the read pointer
   // (modulo DEPTH) is below the count.
   for (genvar g = 0; g < DEPTH; g++) begin : g_valid
      logic [PW-1:0] offA, offB;
      assign offA         = PW'(g) - rdPtrA;
      assign offB         = PW'(g) - rdPtrB;
      assign entValidA[g] = (CW'(offA) < cntA);
      assign entValidB[g] = (CW'(offB) < cntB);
   end

   logic hit1, hit2;

   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entValidA[i] && addrMemA[i] == ReadRegister1) hit1 = 1'b1;
         if (entValidB[i] && addrMemB[i] == ReadRegister1) hit1 = 1'b1;
         if (entValidA[i] && addrMemA[i] == ReadRegister2) hit2 = 1'b1;
         if (entValidB[i] && addrMemB[i] == ReadRegister2) hit2 = 1'b1;
      end
      if (RegWrite && WriteRegister == ReadRegister1) hit1 = 1'b1;
      if (RegWrite && WriteRegister == ReadRegister2) hit2 = 1'b1;
   end

   // Register 0 never hazards: it is never written.
   assign Hazard1 = ResetN && (ReadRegister1 != '0) && hit1;
   assign Hazard2 = ResetN && (ReadRegister2 != '0) && hit2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
   localparam int DEPTH = 2;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          Clk = 1'b0;
   logic          ResetN;
   logic          ValidA, ValidB, ReadyA, ReadyB;
   logic [AW-1:0] AddrA, AddrB, WriteRegister, ReadRegister1, ReadRegister2;
   logic [DW-1:0] DataA, DataB, WriteData;
   logic          RegWrite, Hazard1, Hazard2;

   always #5 Clk = ~Clk;

   regfile_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .Clk(Clk), .ResetN(ResetN),
      .ValidA(ValidA), .ReadyA(ReadyA), .AddrA(AddrA), .DataA(DataA),
      .ValidB(ValidB), .ReadyB(ReadyB), .AddrB(AddrB), .DataB(DataB),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .Hazard1(Hazard1), .Hazard2(Hazard2)
   );

   typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
   typedef struct packed {logic rw; logic [AW-1:0] wr; logic [DW-1:0] wd;} out_t;

   // Reference model: two plain queues, a tie-break flag and the last write.
   ent_t qA[$];
   ent_t qB[$];
   out_t expQ[$];
   logic prioB;
   out_t lastOut;
   int   tests = 0, fails = 0, writesSeen = 0, writesExp = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic hazModel(input logic rn, input logic [AW-1:0] r);
      if (!rn || r == '0) return 1'b0;
      foreach (qA[i]) if (qA[i].a == r) return 1'b1;
      foreach (qB[i]) if (qB[i].a == r) return 1'b1;
      if (lastOut.rw && lastOut.wr == r) return 1'b1;
      return 1'b0;
   endfunction

   // One clock cycle: drive at negedge, check combinational outputs, then
   // advance the model at the rising edge and queue the expected write.
   task automatic cyc(input logic rn,
                      input logic va, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic vb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      logic rdyA, rdyB, g;
      ent_t e;
      out_t o;
      @(negedge Clk);
      ResetN = rn; ValidA = va; AddrA = aa; DataA = da;
      ValidB = vb; AddrB = ab; DataB = db;
      ReadRegister1 = r1; ReadRegister2 = r2;
      #1;
      rdyA = rn && (qA.size() < DEPTH);
      rdyB = rn && (qB.size() < DEPTH);
      chk("ReadyA", 64'(ReadyA), 64'(rdyA));
      chk("ReadyB", 64'(ReadyB), 64'(rdyB));
      chk("Hazard1", 64'(Hazard1), 64'(hazModel(rn, r1)));
      chk("Hazard2", 64'(Hazard2), 64'(hazModel(rn, r2)));
      @(posedge Clk);
      o = '0;
      if (!rn) begin
         qA.delete();
         qB.delete();
         prioB = 1'b0;
      end else begin
         g = 1'b0;
         e = '0;
         if (qA.size() > 0 && (qB.size() == 0 || !prioB)) begin
            e = qA.pop_front(); prioB = 1'b1; g = 1'b1;
         end else if (qB.size() > 0) begin
            e = qB.pop_front(); prioB = 1'b0; g = 1'b1;
         end
         if (g) o = '{(e.a != '0), e.a, e.d};
         if (va && rdyA) qA.push_back('{aa, da});
         if (vb && rdyB) qB.push_back('{ab, db});
      end
      if (o.rw) writesExp++;
      expQ.push_back(o);
      lastOut = o;
   endtask

   task automatic idle(input int n, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
   endtask

   // Monitor: every output cycle is compared against the scoreboard head.
   initial begin
      out_t e;
      forever begin
         @(negedge Clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("WritePort", 64'({RegWrite, WriteRegister, WriteData}), 64'(e));
            if (RegWrite) writesSeen++;
         end
      end
   end

   initial begin
      ResetN = 1'b0; ValidA = 1'b0; ValidB = 1'b0;
      AddrA = '0; AddrB = '0; DataA = '0; DataB = '0;
      ReadRegister1 = '0; ReadRegister2 = '0;
      prioB = 1'b0; lastOut = '0;

      cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
      cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd5, 5'd1);

      // Single write with hazard observation on register 5.
      cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5, 5'd5);
      idle(3, 5'd5, 5'd0);

      // Contention, then a second joint push where B should win first.
      cyc(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd1, 5'd2);
      idle(3, 5'd1, 5'd2);
      cyc(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
      idle(3, 5'd3, 5'd4);

      // Backpressure: both sides pushing so each FIFO fills.
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b1, 5'(16 + i), 32'hA000 + i, 1'b1, 5'(24 + i), 32'hB000 + i, 5'(16 + i), 5'd24);
      for (int i = 4; i < 6; i++)
         cyc(1'b1, 1'b0, '0, '0, 1'b1, 5'(24 + i), 32'hB000 + i, 5'd17, 5'd25);
      idle(5, 5'd16, 5'd29);

      // Register 0 entry is consumed without a write and never hazards.
      cyc(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      idle(3, 5'd0, 5'd0);

      // Wrap-around: 8 back-to-back writes through A.
      for (int i = 0; i < 8; i++)
         cyc(1'b1, 1'b1, 5'(8 + i), 32'(i), 1'b0, '0, '0, 5'(8 + i), 5'd15);
      idle(4, 5'd15, 5'd8);

      // Reset with both FIFOs full; nothing stale may appear afterwards.
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b1, 5'(1 + i), 32'hC0 + i, 1'b1, 5'(9 + i), 32'hD0 + i, 5'd2, 5'd10);
      cyc(1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h78, 5'd3, 5'd11);
      idle(4, 5'd3, 5'd11);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++)
         cyc(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 15)), $urandom,
             ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 15)), $urandom,
             5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      idle(8, 5'd0, 5'd0);

      @(negedge Clk);
      #2;
      chk("ScoreboardDrained", 64'(expQ.size()), 64'd0);
      chk("ModelFifosEmpty", 64'(qA.size() + qB.size()), 64'd0);
      chk("WriteCount", 64'(writesSeen), 64'(writesExp));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
